// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths and FSM state encoding for the 4-to-2 sequential encoder
package encoder_pkg;

    localparam int CODE_W = 2;
    localparam int REQ_W  = 4;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t HOLD = 1'b1;

endpackage

// File: rtl/encoder_4x2_seq_if.sv
// rtl/encoder_4x2_seq_if.sv - request/output bundle for encoder_4x2_seq (ovf only with PENC_OVF_FLAG_EN)
interface encoder_4x2_seq_if;
    import encoder_pkg::*;

    logic [REQ_W-1:0]  req;
    logic              out_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic [REQ_W-1:0]  pending;
`ifdef PENC_OVF_FLAG_EN
    logic              ovf;
`endif

    // Requester / consumer side
    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  pending
`ifdef PENC_OVF_FLAG_EN
        , input ovf
`endif
    );

    // Encoder side
    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output out_code,
        output pending
`ifdef PENC_OVF_FLAG_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/encoder_4x2_seq_prio_sel_4.sv
// rtl/encoder_4x2_seq_prio_sel_4.sv - combinational 4-input priority selector
module prio_sel_4
    import encoder_pkg::*;
#(
    parameter int HI_PRIO_MSB = 1
) (
    input  logic [REQ_W-1:0]  cand,
    output logic [CODE_W-1:0] code,
    output logic [REQ_W-1:0]  onehot,
    output logic              any
);

    // Scan in ascending or descending order so the last hit is the winner
    always_comb begin
        code   = '0;
        onehot = '0;
        any    = |cand;
        if (HI_PRIO_MSB != 0) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (cand[i]) begin
                    code      = CODE_W'(i);
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    code      = CODE_W'(i);
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/encoder_4x2_seq.sv
// rtl/encoder_4x2_seq.sv - sequential 4-to-2 priority encoder with pending capture; optional PENC_OVF_FLAG_EN
module encoder_4x2_seq
    import encoder_pkg::*;
#(
    parameter int HI_PRIO_MSB = 1
) (
    input  logic              clk,
    input  logic              rst,
    encoder_4x2_seq_if.slave  bus
);

    state_t            state;
    logic [CODE_W-1:0] code_q;
    logic [REQ_W-1:0]  pend_q;

    logic [REQ_W-1:0]  cand;
    logic [CODE_W-1:0] sel_code;
    logic [REQ_W-1:0]  sel_onehot;
    logic              sel_any;
    logic              load;
    logic [REQ_W-1:0]  granted;

    prio_sel_4 #(
        .HI_PRIO_MSB (HI_PRIO_MSB)
    ) u_sel (
        .cand   (cand),
        .code   (sel_code),
        .onehot (sel_onehot),
        .any    (sel_any)
    );

    // A new code is taken whenever the output slot is empty or being consumed
    always_comb begin
        cand    = pend_q | bus.req;
        load    = (state == IDLE) || bus.out_ready;
        granted = (load && sel_any) ? sel_onehot : '0;
    end

    // FSM, held code and pending set; a bit granted this cycle also absorbs its same-cycle req
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            code_q <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= cand & ~granted;
            if (load) begin
                if (sel_any) begin
                    state  <= HOLD;
                    code_q <= sel_code;
                end else begin
                    state  <= IDLE;
                    code_q <= '0;
                end
            end
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.out_code  = code_q;
    assign bus.pending   = pend_q;

`ifdef PENC_OVF_FLAG_EN
    logic ovf_q;

    // Sticky: a request arrived for a bit that was already waiting and not granted now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (|(bus.req & pend_q & ~granted)) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
